// File: rtl/spi_master.sv
// SPI master, mode 0 (SCLK idles low, MSB first), one WIDTH-bit full-duplex
// transfer per accepted start. All pin outputs come straight from flops so
// SCLK, SEL_ and MOSI are glitch-free at the PMOD pins.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | SEL_ high, SCLK low, waiting for start
// SETUP | SEL_ low, first MOSI bit settling before the first SCLK rise
// HIGH  | SCLK high; MISO sampled on the edge that ends this phase
// LOW   | SCLK low between bits; MOSI already advanced to the next bit
// HOLD  | SCLK low after the last bit, SEL_ still asserted
// GAP   | SEL_ released, busy still high to space frames apart
module spi_master #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             ucSEL_,
  output logic             ucSCLK,
  output logic             ucMOSI,
  input  logic             ucMISO
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             sel_q, sel_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             phase_end;

  assign phase_end = (div_q == DIV_LAST);

  // State register and all output flops; reset aborts any transfer silently.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      sel_q      <= 1'b1;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      sel_q      <= sel_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: every phase lasts exactly CLKDIV cycles, so the pin
  // edges land on fixed offsets from acceptance regardless of data.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    sel_d      = sel_q;
    sclk_d     = sclk_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q == S_IDLE) begin
      div_d = '0;
    end else if (phase_end) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_d    = data_in;
          sel_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          // MISO has been stable for the whole high phase; take it now.
          rx_d   = {rx_q[WIDTH-2:0], ucMISO};
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = S_HOLD;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = {tx_q[WIDTH-2:0], 1'b0};
            state_d = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          sel_d      = 1'b1;
          data_out_d = rx_q;
          done_d     = 1'b1;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (phase_end) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;
  assign ucSEL_   = sel_q;
  assign ucSCLK   = sclk_q;
  // MOSI is the top of the shift register, so it only moves when tx_q does.
  assign ucMOSI   = tx_q[WIDTH-1];

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a pin-level monitor records edge cycles and bits,
// and each frame is judged against the cycle offsets and bit order of the
// SPI mode-0 protocol computed from acceptance time.
module tb_spi_master;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int W2 = 16;
  localparam int H2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_;
  logic          start;
  logic [W-1:0]  data_in;
  logic          busy, done;
  logic [W-1:0]  data_out;
  logic          ucSEL_, ucSCLK, ucMOSI, ucMISO;

  logic          start2;
  logic [W2-1:0] data_in2;
  logic          busy2, done2;
  logic [W2-1:0] data_out2;
  logic          sel2, sclk2, mosi2, miso2;

  // 0 loopback, 1 tied low, 2 tied high, 3 random slave
  int   miso_mode = 0;
  logic miso_rand = 1'b0;

  assign ucMISO = (miso_mode == 0) ? ucMOSI :
                  (miso_mode == 1) ? 1'b0 :
                  (miso_mode == 2) ? 1'b1 : miso_rand;
  assign miso2  = mosi2;

  spi_master #(.WIDTH(W), .CLKDIV(H)) dut (
    .clk(clk), .reset_(reset_), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out),
    .ucSEL_(ucSEL_), .ucSCLK(ucSCLK), .ucMOSI(ucMOSI), .ucMISO(ucMISO)
  );

  spi_master #(.WIDTH(W2), .CLKDIV(H2)) dut2 (
    .clk(clk), .reset_(reset_), .start(start2), .data_in(data_in2),
    .busy(busy2), .done(done2), .data_out(data_out2),
    .ucSEL_(sel2), .ucSCLK(sclk2), .ucMOSI(mosi2), .ucMISO(miso2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Random slave: changes MISO only while SCLK is low.
  always @(negedge clk) if (!ucSCLK) miso_rand <= 1'($urandom_range(0, 1));

  int sel_fall_q[$], sel_rise_q[$], rise_q[$], fall_q[$], done_q[$], busy_fall_q[$];
  logic [W-1:0] dout_q[$];
  logic mosi_bits[$], miso_bits[$];
  int   mosi_viol = 0;
  logic p_sclk = 1'b0, p_sel = 1'b1, p_mosi = 1'b0, p_busy = 1'b0;

  always @(negedge clk) begin
    if (p_sel === 1'b1 && ucSEL_ === 1'b0) sel_fall_q.push_back(cyc);
    if (p_sel === 1'b0 && ucSEL_ === 1'b1) sel_rise_q.push_back(cyc);
    if (p_sclk === 1'b0 && ucSCLK === 1'b1) begin
      rise_q.push_back(cyc);
      mosi_bits.push_back(ucMOSI);
      miso_bits.push_back(ucMISO);
    end
    if (p_sclk === 1'b1 && ucSCLK === 1'b0) fall_q.push_back(cyc);
    if (ucMOSI !== p_mosi && !(p_sclk === 1'b1 && ucSCLK === 1'b0)
        && !(p_sel === 1'b1 && ucSEL_ === 1'b0)) mosi_viol++;
    if (done === 1'b1) begin
      done_q.push_back(cyc);
      dout_q.push_back(data_out);
    end
    if (p_busy === 1'b1 && busy === 1'b0) busy_fall_q.push_back(cyc);
    p_sclk <= ucSCLK;
    p_sel  <= ucSEL_;
    p_mosi <= ucMOSI;
    p_busy <= busy;
  end

  int rise2_q[$], fall2_q[$], done2_q[$];
  logic [W2-1:0] dout2_q[$];
  logic p_sclk2 = 1'b0;
  always @(negedge clk) begin
    if (p_sclk2 === 1'b0 && sclk2 === 1'b1) rise2_q.push_back(cyc);
    if (p_sclk2 === 1'b1 && sclk2 === 1'b0) fall2_q.push_back(cyc);
    if (done2 === 1'b1) begin
      done2_q.push_back(cyc);
      dout2_q.push_back(data_out2);
    end
    p_sclk2 <= sclk2;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    sel_fall_q.delete(); sel_rise_q.delete(); rise_q.delete(); fall_q.delete();
    done_q.delete(); busy_fall_q.delete(); dout_q.delete();
    mosi_bits.delete(); miso_bits.delete();
    mosi_viol = 0;
  endtask

  // One frame on the default instance; checks every pin timing and both words.
  task automatic run_frame(input logic [W-1:0] d, input int mode,
                           input logic [W-1:0] exp_rx, input bit use_model,
                           input bit poke);
    int t0, bad;
    bit fin;
    logic [W-1:0] mo, mi, want;
    clear_mon();
    miso_mode = mode;
    @(posedge clk); #1;
    data_in = d; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; data_in = W'($urandom);
    fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      if (poke) start = (cyc == t0 + 10 || cyc == t0 + 40);
      if (busy_fall_q.size() > 0) fin = 1'b1;
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("frame_timeout", fin, 1);
    check("sel_fall_count", sel_fall_q.size(), 1);
    check("sel_fall_cycle", sel_fall_q.size() > 0 ? sel_fall_q[0] - t0 : -1, 1);
    check("rise_count", rise_q.size(), W);
    check("fall_count", fall_q.size(), W);
    check("first_rise", rise_q.size() > 0 ? rise_q[0] - t0 : -1, 1 + H);
    bad = 0;
    foreach (rise_q[k]) if (rise_q[k] != t0 + 1 + H + 2*H*k) bad++;
    foreach (fall_q[k]) if (fall_q[k] != t0 + 1 + 2*H + 2*H*k) bad++;
    check("sclk_edge_timing", bad, 0);
    check("done_count", done_q.size(), 1);
    check("done_cycle", done_q.size() > 0 ? done_q[0] - t0 : -1, 1 + 2*H*W + H);
    check("sel_rise_cycle", sel_rise_q.size() > 0 ? sel_rise_q[0] - t0 : -1, 1 + 2*H*W + H);
    check("busy_fall_cycle", busy_fall_q[0] - t0, 1 + 2*H*W + 2*H);
    check("mosi_stability", mosi_viol, 0);
    mo = '0; mi = '0;
    for (int k = 0; k < mosi_bits.size() && k < W; k++) begin
      mo = {mo[W-2:0], mosi_bits[k]};
      mi = {mi[W-2:0], miso_bits[k]};
    end
    check("mosi_word", mo, d);
    want = use_model ? mi : exp_rx;
    check("data_out_at_done", dout_q.size() > 0 ? dout_q[0] : ~want, want);
    check("data_out_hold", data_out, want);
  endtask

  typedef struct {
    logic [W-1:0] d;
    int           mode;
    logic [W-1:0] exp_rx;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int t0;
    bit fin;
    int bad;
    logic [W-1:0] rd;
    int rm;
    logic [W-1:0] rexp;

    vecs[0] = '{8'hA5, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1, 8'h00};
    vecs[2] = '{8'h3C, 2, 8'hFF};
    vecs[3] = '{8'h00, 0, 8'h00};
    vecs[4] = '{8'hFF, 0, 8'hFF};
    vecs[5] = '{8'h01, 1, 8'h00};
    vecs[6] = '{8'h80, 2, 8'hFF};

    reset_ = 1'b0; start = 1'b0; start2 = 1'b0;
    data_in = '0; data_in2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", ucSEL_, 1);
    check("rst_sclk", ucSCLK, 0);
    check("rst_mosi", ucMOSI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data_out", data_out, 0);
    reset_ = 1'b1;

    foreach (vecs[i]) run_frame(vecs[i].d, vecs[i].mode, vecs[i].exp_rx, 1'b0, 1'b0);

    // starts during a transfer must be dropped
    run_frame(8'h5C, 0, 8'h5C, 1'b0, 1'b1);

    for (int n = 0; n < 10; n++) begin
      rd = W'($urandom);
      rm = int'($urandom_range(0, 3));
      rexp = (rm == 0) ? rd : (rm == 1) ? '0 : '1;
      run_frame(rd, rm, rexp, rm == 3, 1'b0);
    end

    // reset mid-transfer
    run_frame(8'hC3, 0, 8'hC3, 1'b0, 1'b0);
    clear_mon();
    miso_mode = 0;
    @(posedge clk); #1;
    data_in = 8'h5A; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1 reset_ = 1'b0;
    @(posedge clk); #1;
    reset_ = 1'b1;
    @(negedge clk);
    check("abort_at_cycle", cyc - t0, 31);
    check("abort_sel", ucSEL_, 1);
    check("abort_sclk", ucSCLK, 0);
    check("abort_mosi", ucMOSI, 0);
    check("abort_busy", busy, 0);
    check("abort_data_out", data_out, 0);
    repeat (100) @(negedge clk);
    check("abort_no_done", done_q.size(), 0);
    check("abort_no_restart", sel_fall_q.size(), 1);
    check("abort_data_out_kept", data_out, 0);
    run_frame(8'h96, 0, 8'h96, 1'b0, 1'b0);

    // start held high: back-to-back frames
    clear_mon();
    miso_mode = 0;
    @(posedge clk); #1;
    data_in = 8'h81; start = 1'b1; t0 = cyc;
    for (int i = 0; i < 400 && done_q.size() < 2; i++) @(negedge clk);
    start = 1'b0;
    check("b2b_done_count", done_q.size(), 2);
    check("b2b_second_sel_fall", sel_fall_q.size() > 1 ? sel_fall_q[1] - t0 : -1, 74);
    check("b2b_second_done", done_q.size() > 1 ? done_q[1] - t0 : -1, 74 + 2*H*W + H);
    check("b2b_data0", dout_q.size() > 0 ? dout_q[0] : 8'h00, 8'h81);
    check("b2b_data1", dout_q.size() > 1 ? dout_q[1] : 8'h00, 8'h81);
    fin = 1'b0;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk);
      if (!busy) fin = 1'b1;
    end
    check("b2b_idle_timeout", fin, 1);
    repeat (5) @(negedge clk);
    check("b2b_no_third", sel_fall_q.size(), 2);

    // 16-bit, half-period 2 instance in loopback
    @(posedge clk); #1;
    data_in2 = 16'hBEEF; start2 = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start2 = 1'b0; data_in2 = 16'h1234;
    for (int i = 0; i < 200 && done2_q.size() == 0; i++) @(negedge clk);
    check("w16_rise_count", rise2_q.size(), W2);
    check("w16_first_rise", rise2_q.size() > 0 ? rise2_q[0] - t0 : -1, 1 + H2);
    bad = 0;
    foreach (rise2_q[k]) if (rise2_q[k] != t0 + 1 + H2 + 2*H2*k) bad++;
    foreach (fall2_q[k]) if (fall2_q[k] != t0 + 1 + 2*H2 + 2*H2*k) bad++;
    check("w16_sclk_timing", bad, 0);
    check("w16_done_cycle", done2_q.size() > 0 ? done2_q[0] - t0 : -1, 67);
    check("w16_data_out", dout2_q.size() > 0 ? dout2_q[0] : 16'h0000, 16'hBEEF);
    repeat (10) @(negedge clk);
    check("w16_idle", busy2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Clocked SPI master (mode 0: SCLK idles low, MSB first) for driving the board's off-chip SPI slaves over PMOD pins, and for exercising our existing SPI slave in loopback. A single `start` strobe launches one WIDTH-bit full-duplex transfer. The block generates ucSEL_, ucSCLK and ucMOSI, samples ucMISO, and returns the received word with a one-cycle `done` pulse. It sits between user logic and the PMOD pin assignments in a board top-level.

## Interface
- WIDTH, 8: bits per transfer (≥2).
- CLKDIV, 4: SCLK half-period H in clk cycles (≥2); SCLK period = 2·CLKDIV clk cycles.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_  in  1  synchronous, active-low reset.
- start  in  1  request a transfer; sampled only while idle (busy=0).
- data_in  in  WIDTH  word to transmit; latched on the accepting cycle.
- busy  out  1  high from the cycle after acceptance until the inter-frame gap ends.
- done  out  1  one-cycle pulse when data_out becomes valid.
- data_out  out  WIDTH  last received word; holds until the next done.
- ucSEL_  out  1  active-low slave select.
- ucSCLK  out  1  serial clock.
- ucMOSI  out  1  master-out data.
- ucMISO  in  1  master-in data.

## Operation
- State machine: IDLE → SETUP → HIGH ↔ LOW → HOLD → GAP → IDLE.
- Divider counter runs 0..H−1 in every non-IDLE state. Bit counter runs 0..WIDTH−1.
- IDLE:
  - Outputs: ucSEL_=1, ucSCLK=0, busy=0.
  - start=1 at cycle T0: latch data_in into the tx shift register and enter SETUP.
  - At T0+1: ucSEL_=0, ucMOSI=data_in[WIDTH−1], busy=1.
- SETUP (H cycles): SEL low, SCLK low, MOSI stable. Then drive ucSCLK=1 and enter HIGH.
- HIGH (H cycles):
  - On the clk edge that ends HIGH, shift ucMISO into the rx register LSB. This captures the value stable for the whole high phase.
  - The same edge drives ucSCLK=0.
  - If bits remain, advance MOSI to the next bit and enter LOW. Otherwise enter HOLD, with MOSI unchanged.
- LOW (H cycles): then ucSCLK=1 and enter HIGH.
- HOLD (H cycles):
  - Then ucSEL_=1, data_out=rx register, done=1 for exactly that cycle.
  - Enter GAP.
- GAP (H cycles): ucSEL_=1, busy=1. Then busy=0 and enter IDLE.
- start while busy=1 is ignored. It is not queued.
- start held high continuously produces back-to-back transfers, each separated by the GAP.
- data_in changes after the accepting cycle have no effect on the current transfer.
- Reset (reset_=0 at a clk edge, in any state including mid-transfer):
  - Next cycle: IDLE, ucSEL_=1, ucSCLK=0, ucMOSI=0, busy=0, done=0, data_out=0, counters=0.
  - The aborted transfer produces no done.

## Timing
- Let H=CLKDIV and W=WIDTH, with acceptance at T0.
- ucSEL_ falls at T0+1.
- Rising SCLK edges at T0+1+H+2Hk, for k=0..W−1.
- Falling SCLK edges at T0+1+2H+2Hk. MISO bit k is sampled at the falling-edge cycle.
- MOSI changes only at falling SCLK edges (and at T0+1), never while SCLK is high.
- Last fall at T0+1+2HW.
- ucSEL_ rises together with done and data_out update at T0+1+2HW+H.
- busy falls at T0+1+2HW+2H. The earliest next acceptance is that same cycle.
- Defaults (W=8, H=4): SEL_ low T0+1, first rise T0+5, last fall T0+65, done T0+69, busy low T0+73.
- Transfer latency is independent of data. ucSCLK has no glitches and a duty cycle of exactly 50 %.

## Test plan
- Loopback, ucMOSI tied to ucMISO, default params, start with data_in=0xA5 at T0 → 8 SCLK rises (first at T0+5), done one cycle at T0+69, data_out=0xA5, ucSEL_ high at T0+69, busy low at T0+73.
- ucMISO tied 0 then 1, data_in=0x3C → ucMOSI bit sequence 0,0,1,1,1,1,0,0 on the rises; data_out=0x00 then 0xFF.
- Pulse start again at T0+10 and T0+40 during a transfer → ignored. Exactly one done; next transfer only after busy=0.
- reset_=0 for one cycle at T0+30 → next cycle ucSEL_=1, ucSCLK=0, busy=0, data_out=0. No done pulse; a new start works normally.
- start held high with data_in=0x81 → back-to-back frames; second ucSEL_ falls at T0+74; each frame done with data_out=0x81 in loopback.
- WIDTH=16, CLKDIV=2, loopback 0xBEEF → 16 rises, SCLK period 4 cycles, done at T0+1+64+2=T0+67, data_out=0xBEEF.
